// File: rtl/umi_mport_ram.sv
// umi_mport_ram: N-port UMI RAM with round-robin arbitration and per-port response slots
module umi_mport_ram #(
  parameter int N        = 5,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 256,
  parameter int RAMDEPTH = 512,
  parameter int CTRLW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CTRLW-1:0] sram_ctrl,
  input  logic [N-1:0]    udev_req_valid,
  input  logic [N*CW-1:0] udev_req_cmd,
  input  logic [N*AW-1:0] udev_req_dstaddr,
  input  logic [N*AW-1:0] udev_req_srcaddr,
  input  logic [N*DW-1:0] udev_req_data,
  output logic [N-1:0]    udev_req_ready,
  output logic [N-1:0]    udev_resp_valid,
  output logic [N*CW-1:0] udev_resp_cmd,
  output logic [N*AW-1:0] udev_resp_dstaddr,
  output logic [N*AW-1:0] udev_resp_srcaddr,
  output logic [N*DW-1:0] udev_resp_data,
  input  logic [N-1:0]    udev_resp_ready
);
  localparam int B  = DW / 8;
  localparam int OW = $clog2(B);
  localparam int IW = $clog2(RAMDEPTH);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  logic [DW-1:0] mem [RAMDEPTH];
  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic          gnt;
  logic [N-1:0]  elig, rv_q;
  logic [CW-1:0] rc_q [N];
  logic [AW-1:0] rd_q [N];
  logic [AW-1:0] rs_q [N];
  logic [DW-1:0] rdat_q [N];
  logic [CW-1:0] cmd_a [N];
  logic [AW-1:0] dst_a [N];
  logic [AW-1:0] src_a [N];
  logic [DW-1:0] dat_a [N];
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dst, sel_src;
  logic [DW-1:0] sel_data, wdata, rdata, rmask;
  logic [4:0]    op;
  logic [OW-1:0] off;
  logic [IW-1:0] widx;
  logic [16:0]   nb;
  logic [B-1:0]  be;
  logic          wr, rsp;
  logic          unused;

  assign unused = ^sram_ctrl;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_port
      assign cmd_a[g] = udev_req_cmd[g*CW +: CW];
      assign dst_a[g] = udev_req_dstaddr[g*AW +: AW];
      assign src_a[g] = udev_req_srcaddr[g*AW +: AW];
      assign dat_a[g] = udev_req_data[g*DW +: DW];
      assign elig[g] = udev_req_valid[g] & ((cmd_a[g][4:0] == REQ_POSTED) | ~rv_q[g] | udev_resp_ready[g]);
      assign udev_req_ready[g] = ~reset & gnt & (gidx == PW'(g));
      assign udev_resp_cmd[g*CW +: CW] = rc_q[g];
      assign udev_resp_dstaddr[g*AW +: AW] = rd_q[g];
      assign udev_resp_srcaddr[g*AW +: AW] = rs_q[g];
      assign udev_resp_data[g*DW +: DW] = rdat_q[g];
    end
  endgenerate

  assign udev_resp_valid = rv_q;
  assign sel_cmd  = cmd_a[gidx];
  assign sel_dst  = dst_a[gidx];
  assign sel_src  = src_a[gidx];
  assign sel_data = dat_a[gidx];
  assign op   = sel_cmd[4:0];
  assign off  = sel_dst[OW-1:0];
  assign widx = sel_dst[OW +: IW];
  assign nb   = (17'(sel_cmd[15:8]) + 17'd1) << sel_cmd[7:5];
  assign wdata = sel_data << {off, 3'b000};
  assign rdata = (mem[widx] >> {off, 3'b000}) & rmask;
  assign wr  = gnt & ~reset & ((op == REQ_WRITE) | (op == REQ_POSTED));
  assign rsp = gnt & ~reset & ((op == REQ_READ) | (op == REQ_WRITE));

  // first eligible port at or after the pointer wins; pointer moves past the winner
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int j = 0; j < N; j++)
      if (!gnt && elig[(int'(ptr_q) + j) % N]) begin
        gnt  = 1'b1;
        gidx = PW'((int'(ptr_q) + j) % N);
      end
    ptr_d = !gnt ? ptr_q : (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
  end

  // write byte enables from offset/length, and read mask truncating bytes past NB
  always_comb begin
    be    = '0;
    rmask = '0;
    for (int j = 0; j < B; j++) begin
      be[j] = (j >= int'(off)) && ((j - int'(off)) < int'(nb));
      rmask[j*8 +: 8] = (j < int'(nb)) ? 8'hff : 8'h00;
    end
  end

  // byte-granular RAM write, committed at the end of the accept cycle
  always_ff @(posedge clk)
    if (wr)
      for (int j = 0; j < B; j++)
        if (be[j]) mem[widx][j*8 +: 8] <= wdata[j*8 +: 8];

  // arbiter pointer and one-deep response slots; a drained slot can refill in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < N; i++) begin
        rv_q[i]   <= 1'b0;
        rc_q[i]   <= '0;
        rd_q[i]   <= '0;
        rs_q[i]   <= '0;
        rdat_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < N; i++)
        if (rsp && int'(gidx) == i) begin
          rv_q[i]   <= 1'b1;
          rc_q[i]   <= {sel_cmd[CW-1:5], (op == REQ_READ) ? RESP_READ : RESP_WRITE};
          rd_q[i]   <= sel_src;
          rs_q[i]   <= sel_dst;
          rdat_q[i] <= (op == REQ_READ) ? rdata : '0;
        end else if (udev_resp_ready[i]) rv_q[i] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_umi_mport_ram.sv
// tb_umi_mport_ram: directed table, corner sequences and random traffic against a byte-array model
module tb_umi_mport_ram;
  localparam int N = 5, CW = 32, AW = 64, DW = 256, RD = 512, B = 32;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] sram_ctrl = 8'h00;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready, last_ready;
  logic [N*CW-1:0] req_cmd, resp_cmd;
  logic [N*AW-1:0] req_dst, req_src, resp_dst, resp_src;
  logic [N*DW-1:0] req_data, resp_data;
  logic [CW-1:0] c [N];
  logic [AW-1:0] da [N];
  logic [AW-1:0] sa [N];
  logic [DW-1:0] wd [N];

  logic [7:0] mm [RD*B];
  int ptr_m;
  bit sv [N];
  logic [CW-1:0] scmd [N];
  logic [AW-1:0] sdst [N];
  logic [AW-1:0] ssrc [N];
  logic [DW-1:0] sdat [N];
  int total = 0, bad = 0;

  typedef struct {
    logic [N-1:0] v, pst, rr, er;
  } vec_t;
  vec_t tbl [20];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_cmd[i*CW +: CW]  = c[i];
      req_dst[i*AW +: AW]  = da[i];
      req_src[i*AW +: AW]  = sa[i];
      req_data[i*DW +: DW] = wd[i];
    end

  umi_mport_ram #(.N(N), .CW(CW), .AW(AW), .DW(DW), .RAMDEPTH(RD), .CTRLW(8)) dut (
    .clk(clk), .reset(rst), .sram_ctrl(sram_ctrl),
    .udev_req_valid(req_valid), .udev_req_cmd(req_cmd), .udev_req_dstaddr(req_dst),
    .udev_req_srcaddr(req_src), .udev_req_data(req_data), .udev_req_ready(req_ready),
    .udev_resp_valid(resp_valid), .udev_resp_cmd(resp_cmd), .udev_resp_dstaddr(resp_dst),
    .udev_resp_srcaddr(resp_src), .udev_resp_data(resp_data), .udev_resp_ready(resp_ready)
  );

  task automatic chk(input string nm, input logic [415:0] a, input logic [415:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int op, input int sz, input int ln);
    mk = {16'($urandom), 8'(ln), 3'(sz), 5'(op)};
  endfunction

  function automatic logic [AW-1:0] addr(input int w, input int off, input bit rnd);
    logic [AW-1:0] a;
    a = rnd ? {$urandom, $urandom} : '0;
    a[13:0] = {9'(w), 5'(off)};
    return a;
  endfunction

  function automatic logic [DW-1:0] pat(input int w);
    for (int j = 0; j < B; j++) pat[j*8 +: 8] = 8'(w * 32 + j) ^ 8'h5A;
  endfunction

  // one clock: check grant against the model, advance the model, check responses
  task automatic cyc();
    int g, op, sz, ln, off, w, nb;
    logic [N-1:0] er, mv;
    #1;
    g = -1;
    if (!rst)
      for (int j = 0; j < N; j++) begin
        int k;
        k = (ptr_m + j) % N;
        if (g < 0 && req_valid[k] && (c[k][4:0] == 5'h05 || !sv[k] || resp_ready[k])) g = k;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    last_ready = req_ready;
    @(posedge clk);
    if (rst) begin
      ptr_m = 0;
      for (int k = 0; k < N; k++) begin
        sv[k] = 0; scmd[k] = '0; sdst[k] = '0; ssrc[k] = '0; sdat[k] = '0;
      end
    end else begin
      for (int k = 0; k < N; k++) if (sv[k] && resp_ready[k]) sv[k] = 0;
      if (g >= 0) begin
        op = int'(c[g][4:0]); sz = int'(c[g][7:5]); ln = int'(c[g][15:8]);
        off = int'(da[g][4:0]); w = int'(da[g][13:5]); nb = (ln + 1) << sz;
        if (op == 3 || op == 5)
          for (int j = off; j < B && j - off < nb; j++) mm[w*B + j] = wd[g][(j-off)*8 +: 8];
        if (op == 1 || op == 3) begin
          sv[g] = 1;
          scmd[g] = {c[g][CW-1:5], (op == 1) ? 5'h02 : 5'h04};
          sdst[g] = sa[g];
          ssrc[g] = da[g];
          sdat[g] = '0;
          if (op == 1)
            for (int t = 0; t < B && off + t < B && t < nb; t++) sdat[g][t*8 +: 8] = mm[w*B + off + t];
        end
        ptr_m = (g + 1) % N;
      end
    end
    #1;
    for (int k = 0; k < N; k++) mv[k] = sv[k];
    chk("resp_valid", resp_valid, mv);
    for (int k = 0; k < N; k++)
      if (sv[k] || rst)
        chk($sformatf("resp_fields_p%0d", k),
            {resp_cmd[k*CW +: CW], resp_dst[k*AW +: AW], resp_src[k*AW +: AW], resp_data[k*DW +: DW]},
            {scmd[k], sdst[k], ssrc[k], sdat[k]});
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0;
    resp_ready = '1;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '1;
    for (int i = 0; i < N; i++) begin
      c[i] = '0; da[i] = '0; sa[i] = '0; wd[i] = '0;
    end
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    // known contents for words 0..7
    for (int w = 0; w < 8; w++) begin
      req_valid = 5'b00001;
      c[0] = mk(5, 5, 0); da[0] = addr(w, 0, 0); wd[0] = pat(w);
      cyc();
    end
    idle();
    // posted write then read on port 0
    req_valid = 5'b00001;
    c[0] = mk(5, 3, 0); da[0] = 64'h40; wd[0] = 256'h1122334455667788;
    cyc();
    c[0] = mk(1, 3, 0); sa[0] = 64'hABCD_0000_1234_5678;
    cyc();
    chk("rd_valid", resp_valid[0], 1'b1);
    chk("rd_opcode", resp_cmd[4:0], 5'h02);
    chk("rd_data", resp_data[63:0], 64'h1122334455667788);
    chk("rd_dstaddr", resp_dst[63:0], 64'hABCD_0000_1234_5678);
    idle();
    // fairness and backpressure isolation table, from pointer 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tbl[i] = '{5'b11111, 5'b00000, 5'b11111, 5'b00001 << (i % 5)};
    tbl[6]  = '{5'b11111, 5'b00000, 5'b11011, 5'b00010};
    tbl[7]  = '{5'b11111, 5'b00000, 5'b11011, 5'b00100};
    tbl[8]  = '{5'b11111, 5'b00000, 5'b11011, 5'b01000};
    tbl[9]  = '{5'b11111, 5'b00000, 5'b11011, 5'b10000};
    tbl[10] = '{5'b11111, 5'b00000, 5'b11011, 5'b00001};
    tbl[11] = '{5'b11111, 5'b00000, 5'b11011, 5'b00010};
    tbl[12] = '{5'b11111, 5'b00000, 5'b11011, 5'b01000};
    tbl[13] = '{5'b11111, 5'b00000, 5'b11011, 5'b10000};
    tbl[14] = '{5'b11111, 5'b00100, 5'b11011, 5'b00001};
    tbl[15] = '{5'b11111, 5'b00100, 5'b11011, 5'b00010};
    tbl[16] = '{5'b11111, 5'b00100, 5'b11011, 5'b00100};
    tbl[17] = '{5'b11111, 5'b00100, 5'b11011, 5'b01000};
    tbl[18] = '{5'b11111, 5'b00000, 5'b11111, 5'b10000};
    tbl[19] = '{5'b11111, 5'b00000, 5'b11111, 5'b00001};
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        c[i] = mk(tbl[t].pst[i] ? 5 : 1, 3, 0);
        da[i] = addr(i, 8 * (t % 4), 0);
        sa[i] = {$urandom, $urandom};
        wd[i] = {8{$urandom}};
      end
      req_valid = tbl[t].v;
      resp_ready = tbl[t].rr;
      cyc();
      chk($sformatf("tbl_ready_%0d", t), last_ready, tbl[t].er);
    end
    idle();
    // partial write near the end of word 3, truncated at the word boundary
    req_valid = 5'b01000;
    c[3] = mk(3, 0, 3); da[3] = 64'h7E; wd[3] = 256'hDDCCBBAA;
    cyc();
    chk("wr_opcode", resp_cmd[3*CW +: 5], 5'h04);
    chk("wr_data", resp_data[3*DW +: DW], '0);
    c[3] = mk(1, 5, 0); da[3] = 64'h60;
    cyc();
    chk("trunc_hi", resp_data[3*DW + 240 +: 16], 16'hBBAA);
    chk("trunc_lo", resp_data[3*DW +: 240], pat(3) & {16'h0, {240{1'b1}}});
    idle();
    // unsupported opcode is consumed silently
    req_valid = 5'b00010;
    c[1] = mk(7, 0, 0); da[1] = addr(1, 0, 0);
    cyc();
    chk("op7_ready", last_ready, 5'b00010);
    chk("op7_noresp", resp_valid[1], 1'b0);
    idle();
    // reset with three responses pending
    resp_ready = 5'b11000;
    req_valid = 5'b00111;
    for (int i = 0; i < N; i++) begin
      c[i] = mk(1, 2, 1); da[i] = addr(i, 4, 1); sa[i] = {$urandom, $urandom};
    end
    repeat (3) cyc();
    chk("pending3", resp_valid, 5'b00111);
    rst = 1'b1;
    req_valid = 5'b11111;
    cyc();
    chk("rst_valid", resp_valid, 5'b00000);
    chk("rst_ready", last_ready, 5'b00000);
    rst = 1'b0;
    resp_ready = '1;
    cyc();
    chk("post_rst_gnt", last_ready, 5'b00001);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        int r, op;
        r = $urandom_range(0, 19);
        op = (r < 8) ? 1 : (r < 13) ? 3 : (r < 19) ? 5 : 7;
        c[i] = mk(op, $urandom_range(0, 5), ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 7));
        da[i] = addr($urandom_range(0, 7), $urandom_range(0, 31), 1);
        sa[i] = {$urandom, $urandom};
        wd[i] = {8{$urandom}};
        req_valid[i] = ($urandom_range(0, 9) < 6);
        resp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
